// File: rtl/key_event_gen.sv
// key_event_gen: two-button front end for the watch UI.
// Each raw active-low button is synchronized, debounced and timed; the block emits a
// one-cycle key_first pulse per accepted press and a key_long level while the button
// stays held past LONG_MS.
// Optional feature macro: KEY_REPEAT_EN (auto-repeat key_first pulses while in the long-hold phase).
module key_event_gen #(
    parameter int unsigned IN_CLK_HZ   = 50_000_000,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 1000,
    parameter int unsigned REPEAT_MS   = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_1,
    input  logic key_n_2,
    output logic key_first_1,
    output logic key_first_2,
    output logic key_long_1,
    output logic key_long_2
);

    localparam int unsigned TICK_DIV = ((IN_CLK_HZ / 1000) > 1) ? (IN_CLK_HZ / 1000) : 1;
    localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned MAX_DL   = (DEBOUNCE_MS > LONG_MS) ? DEBOUNCE_MS : LONG_MS;
    localparam int unsigned MAX_P    = (MAX_DL > REPEAT_MS) ? MAX_DL : REPEAT_MS;
    localparam int unsigned CW       = $clog2(MAX_P) + 1;
    localparam int unsigned NKEYS    = 2;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DEB_PRESS = 3'd1,
        S_PRESSED   = 3'd2,
        S_LONG      = 3'd3,
        S_DEB_REL   = 3'd4
    } state_e;

    logic [PW-1:0]    pre_q, pre_d;
    logic             tick_c;
    logic [NKEYS-1:0] sync1_q, sync1_d;
    logic [NKEYS-1:0] sync2_q, sync2_d;
    logic [NKEYS-1:0] pressed_c;
    logic [NKEYS-1:0] first_v;
    logic [NKEYS-1:0] long_v;

    // Shared ms prescaler and two-flop input synchronizers (next-state)
    always_comb begin
        tick_c  = (pre_q == PW'(TICK_DIV - 1));
        pre_d   = tick_c ? '0 : pre_q + PW'(1);
        sync1_d = {key_n_2, key_n_1};
        sync2_d = sync1_q;
    end

    // Prescaler and synchronizer registers; synchronizers reset to "released"
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q   <= '0;
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            pre_q   <= pre_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign pressed_c = ~sync2_q;

    for (genvar g = 0; g < NKEYS; g++) begin : g_key
        state_e        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          first_q, first_d;
        logic          long_q, long_d;

        // Debounce / press-length FSM: next state, ms counter and event outputs
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            first_d = 1'b0;
            long_d  = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pressed_c[g]) begin
                        state_d = S_DEB_PRESS;
                        cnt_d   = '0;
                    end
                end
                S_DEB_PRESS: begin
                    if (!pressed_c[g]) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (tick_c) begin
                        if (cnt_q == CW'(DEBOUNCE_MS - 1)) begin
                            state_d = S_PRESSED;
                            cnt_d   = '0;
                            first_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                S_PRESSED: begin
                    if (!pressed_c[g]) begin
                        state_d = S_DEB_REL;
                        cnt_d   = '0;
                    end else if (tick_c) begin
                        if (cnt_q == CW'(LONG_MS - 1)) begin
                            state_d = S_LONG;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                S_LONG: begin
                    if (!pressed_c[g]) begin
                        state_d = S_DEB_REL;
                        cnt_d   = '0;
                    end else begin
`ifdef KEY_REPEAT_EN
                        if (tick_c) begin
                            if (cnt_q == CW'(REPEAT_MS - 1)) begin
                                cnt_d   = '0;
                                first_d = 1'b1;
                            end else begin
                                cnt_d = cnt_q + CW'(1);
                            end
                        end
`else
                        cnt_d = '0;
`endif
                    end
                end
                S_DEB_REL: begin
                    if (pressed_c[g]) begin
                        cnt_d = '0;
                    end else if (tick_c) begin
                        if (cnt_q == CW'(DEBOUNCE_MS - 1)) begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
            long_d = (state_d == S_LONG);
        end

        // FSM and output registers
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                first_q <= 1'b0;
                long_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                first_q <= first_d;
                long_q  <= long_d;
            end
        end

        assign first_v[g] = first_q;
        assign long_v[g]  = long_q;
    end

    assign key_first_1 = first_v[0];
    assign key_first_2 = first_v[1];
    assign key_long_1  = long_v[0];
    assign key_long_2  = long_v[1];

endmodule

// File: tb/tb_key_event_gen.sv
// Bench for key_event_gen: random bouncing button activity on both keys, checked against
// a run-length reference model through per-key event scoreboards.
module tb_key_event_gen;

    localparam int DEB = 4;
    localparam int LNG = 20;
    localparam int REP = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_n_1 = 1'b1;
    logic key_n_2 = 1'b1;
    logic key_first_1, key_first_2, key_long_1, key_long_2;

    key_event_gen #(
        .IN_CLK_HZ  (1000),
        .DEBOUNCE_MS(DEB),
        .LONG_MS    (LNG),
        .REPEAT_MS  (REP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_n_1    (key_n_1),
        .key_n_2    (key_n_2),
        .key_first_1(key_first_1),
        .key_first_2(key_first_2),
        .key_long_1 (key_long_1),
        .key_long_2 (key_long_2)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Expected events: key_first stamps, key_long stamps encoded as cycle*2+level
    int fq1[$];
    int fq2[$];
    int lq1[$];
    int lq2[$];

    // Reference model state (per key: run lengths of the sampled level)
    logic [1:0] m_s1 = 2'b11;
    logic [1:0] m_s2 = 2'b11;
    bit m_down[2];
    bit m_rel[2];
    int m_runp[2];
    int m_runr[2];
    int m_held[2];
    bit m_rst_edge = 1'b0;

    task automatic push_first(input int k, input int c);
        if (k == 0) fq1.push_back(c); else fq2.push_back(c);
    endtask

    task automatic push_long(input int k, input int c, input int lvl);
        if (k == 0) lq1.push_back(c * 2 + lvl); else lq2.push_back(c * 2 + lvl);
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_down[k] = 0; m_rel[k] = 0;
            m_runp[k] = 0; m_runr[k] = 0; m_held[k] = 0;
        end
    endtask

    // One sampled pressed value for key k at the current edge
    task automatic model_step(input int k, input bit p);
        if (m_down[k]) begin
            if (p) begin
                m_held[k]++;
                if (m_held[k] == LNG) push_long(k, cyc, 1);
`ifdef KEY_REPEAT_EN
                if (m_held[k] > LNG && ((m_held[k] - LNG) % REP) == 0) push_first(k, cyc);
`endif
            end else begin
                if (m_held[k] >= LNG) push_long(k, cyc, 0);
                m_down[k] = 0;
                m_rel[k]  = 1;
                m_runr[k] = 0;
            end
        end else if (m_rel[k]) begin
            m_runr[k] = p ? 0 : m_runr[k] + 1;
            if (m_runr[k] == DEB) begin
                m_rel[k]  = 0;
                m_runp[k] = 0;
            end
        end else begin
            m_runp[k] = p ? m_runp[k] + 1 : 0;
            if (m_runp[k] == DEB + 1) begin
                push_first(k, cyc);
                m_down[k] = 1;
                m_held[k] = 0;
            end
        end
    endtask

    // Reference model advances on every active edge alongside the DUT
    always @(posedge clk) begin
        logic [1:0] p;
        cyc = cyc + 1;
        m_rst_edge = rst;
        if (rst) begin
            for (int k = 0; k < 2; k++)
                if (m_down[k] && m_held[k] >= LNG) push_long(k, cyc, 0);
            model_clear();
            m_s1 = 2'b11;
            m_s2 = 2'b11;
        end else begin
            p    = ~m_s2;
            m_s2 = m_s1;
            m_s1 = {key_n_2, key_n_1};
            for (int k = 0; k < 2; k++) model_step(k, p[k]);
        end
    end

    task automatic check_first(input int k);
        int exp_c;
        n_cmp++;
        if ((k == 0 && fq1.size() == 0) || (k == 1 && fq2.size() == 0)) begin
            n_bad++;
            $display("FAIL key_first_%0d: pulse at cycle %0d, expected none", k + 1, cyc);
        end else begin
            exp_c = (k == 0) ? fq1.pop_front() : fq2.pop_front();
            if (exp_c != cyc) begin
                n_bad++;
                $display("FAIL key_first_%0d: pulse at cycle %0d, expected cycle %0d", k + 1, cyc, exp_c);
            end
        end
    endtask

    task automatic check_long(input int k, input logic lvl);
        int exp_e;
        n_cmp++;
        if ((k == 0 && lq1.size() == 0) || (k == 1 && lq2.size() == 0)) begin
            n_bad++;
            $display("FAIL key_long_%0d: went %0b at cycle %0d, expected no change", k + 1, lvl, cyc);
        end else begin
            exp_e = (k == 0) ? lq1.pop_front() : lq2.pop_front();
            if (exp_e != cyc * 2 + int'(lvl)) begin
                n_bad++;
                $display("FAIL key_long_%0d: went %0b at cycle %0d, expected %0d at cycle %0d",
                         k + 1, lvl, cyc, exp_e % 2, exp_e / 2);
            end
        end
    endtask

    logic [1:0] prev_long = 2'b00;

    // Monitor: samples DUT outputs on the falling edge and pops the scoreboards
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (m_rst_edge) begin
                n_cmp++;
                if ({key_first_2, key_first_1, key_long_2, key_long_1} != 4'b0000) begin
                    n_bad++;
                    $display("FAIL reset_outputs: got %b, expected 0000",
                             {key_first_2, key_first_1, key_long_2, key_long_1});
                end
            end
            if (key_first_1) check_first(0);
            if (key_first_2) check_first(1);
            if (key_long_1 != prev_long[0]) check_long(0, key_long_1);
            if (key_long_2 != prev_long[1]) check_long(1, key_long_2);
            prev_long = {key_long_2, key_long_1};
        end
    end

    task automatic check_empty(input string name, input int left);
        n_cmp++;
        if (left != 0) begin
            n_bad++;
            $display("FAIL %s: %0d expected events never seen, required 0", name, left);
        end
    endtask

    int rem[2];
    logic lvl[2];

    function automatic int pick_len();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 45) return int'($urandom_range(1, 7));
        else if (r < 80) return int'($urandom_range(8, 30));
        else return int'($urandom_range(30, 60));
    endfunction

    // Stimulus: random level run lengths per key, occasional reset pulses
    initial begin
        model_clear();
        rem[0] = 0; rem[1] = 0;
        lvl[0] = 1'b1; lvl[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (rem[k] == 0) begin
                    lvl[k] = ~lvl[k];
                    rem[k] = pick_len();
                end
                rem[k]--;
            end
            key_n_1 = lvl[0];
            key_n_2 = lvl[1];
            rst = ($urandom_range(0, 1499) == 0);
        end
        key_n_1 = 1'b1;
        key_n_2 = 1'b1;
        rst     = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        #1;
        check_empty("first_1_pending", fq1.size());
        check_empty("first_2_pending", fq2.size());
        check_empty("long_1_pending", lq1.size());
        check_empty("long_2_pending", lq2.size());
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
